spp_controller: RTL

SPP_CONTROLLER -- requirements
Module: spp_controller

---
 rtl/spp_pkg.sv | 19 +
 rtl/spp_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/spp_pkg.sv
// Shared types and sizes for the serial even-element product controller.
package spp_pkg;

  localparam int unsigned SPP_ROWS = 16;
  localparam int unsigned SPP_COLS = 16;
  localparam int unsigned EVEN_W   = 9;
  localparam int unsigned CYC_W    = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    ROW      = 3'd2,
    COL      = 3'd3,
    NEXT_ROW = 3'd4,
    STORE    = 3'd5,
    DONE     = 3'd6
  } spp_state_e;

endpackage

// File: rtl/spp_controller.sv
// Row/column walker that sequences the product datapath over even elements,
// with run statistics (even element count, busy cycle count).
module spp_controller
  import spp_pkg::*;
#(
  parameter int unsigned ROWS = SPP_ROWS,
  parameter int unsigned COLS = SPP_COLS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              is_even,
  input  logic              i_lt,
  input  logic              eq,
  output logic              dp_clr,
  output logic              dp_rst,
  output logic              Sj,
  output logic              Ld_i,
  output logic              Ld_j,
  output logic              Ld_p,
  output logic              Ld_r,
  output logic              busy,
  output logic              done,
  output logic [EVEN_W-1:0] even_cnt,
  output logic [CYC_W-1:0]  cycle_cnt
);

  localparam int unsigned EVEN_MAX = ROWS * COLS;

  spp_state_e         state_q, state_d;
  logic [EVEN_W-1:0]  even_cnt_q, even_cnt_d;
  logic [CYC_W-1:0]   cycle_cnt_q, cycle_cnt_d;

  // State and statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      even_cnt_q  <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      even_cnt_q  <= even_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  // Next state, decoded strobes and counter updates.
  always_comb begin
    state_d     = state_q;
    dp_clr      = 1'b0;
    Sj          = 1'b0;
    Ld_i        = 1'b0;
    Ld_j        = 1'b0;
    Ld_p        = 1'b0;
    Ld_r        = 1'b0;
    done        = 1'b0;
    busy        = (state_q != IDLE);
    even_cnt_d  = even_cnt_q;
    cycle_cnt_d = cycle_cnt_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) state_d = INIT;
      end
      INIT: begin
        dp_clr  = 1'b1;
        state_d = ROW;
      end
      ROW: begin
        state_d = i_lt ? COL : STORE;
      end
      COL: begin
        if (eq) begin
          state_d = NEXT_ROW;
        end else begin
          Ld_j = 1'b1;
          Sj   = 1'b1;
          Ld_p = is_even;
        end
      end
      NEXT_ROW: begin
        Ld_i    = 1'b1;
        Ld_j    = 1'b1;
        state_d = ROW;
      end
      STORE: begin
        Ld_r    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort cancels the current cycle's side effects so counters freeze as seen.
    if (busy && abort) begin
      state_d = IDLE;
      dp_clr  = 1'b0;
      Sj      = 1'b0;
      Ld_i    = 1'b0;
      Ld_j    = 1'b0;
      Ld_p    = 1'b0;
      Ld_r    = 1'b0;
      done    = 1'b0;
    end

    // cycle_cnt includes the current busy cycle, so it reads 1 in INIT.
    if (state_q == IDLE && state_d == INIT) begin
      even_cnt_d  = '0;
      cycle_cnt_d = CYC_W'(1);
    end else if (state_d != IDLE && cycle_cnt_q != '1) begin
      cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
    end

    if (Ld_p && even_cnt_q < EVEN_W'(EVEN_MAX)) begin
      even_cnt_d = even_cnt_q + EVEN_W'(1);
    end
  end

  assign dp_rst    = reset | dp_clr;
  assign even_cnt  = even_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule
